// File: rtl/v_pkg.sv
// Shared types for the command scheduler.
//   id_t / level_t / key_t / volume_t : field widths of query and update requests
//   cmd_t                             : update opcodes
//   upd_cmd_t                         : one queued update command
//   UPD_STAGES_N_DEF                  : default depth of the update pipeline shadow
package v_pkg;

    localparam int ID_W             = 8;
    localparam int LEVEL_W          = 4;
    localparam int KEY_W            = 16;
    localparam int VOLUME_W         = 16;
    localparam int UPD_STAGES_N_DEF = 4;

    typedef logic [ID_W-1:0]     id_t;
    typedef logic [LEVEL_W-1:0]  level_t;
    typedef logic [KEY_W-1:0]    key_t;
    typedef logic [VOLUME_W-1:0] volume_t;

    typedef enum logic [1:0] {
        CMD_INSERT  = 2'd0,
        CMD_DELETE  = 2'd1,
        CMD_REPLACE = 2'd2,
        CMD_CLEAR   = 2'd3
    } cmd_t;

    typedef struct packed {
        cmd_t    cmd;
        id_t     prod_id;
        key_t    key;
        volume_t volume;
    } upd_cmd_t;

endpackage

// File: rtl/v_cmd_sched_fifo.sv
// Synchronous FIFO of update commands with registered head storage.
//   clk, arst_n       : clock, asynchronous active-low reset
//   i_push, i_push_data : write request and data (ignored when full without a pop)
//   i_pop             : remove head (ignored when empty)
//   o_head            : current head entry (valid when !o_empty)
//   o_full, o_empty   : derived from registered occupancy
//   o_occ             : occupancy 0..DEPTH
module v_cmd_sched_fifo
    import v_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             i_push,
    input  upd_cmd_t         i_push_data,
    input  logic             i_pop,
    output upd_cmd_t         o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [OCC_W-1:0] o_occ
);

    upd_cmd_t         mem_q [DEPTH];
    upd_cmd_t         mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             do_push;
    logic             do_pop;

    assign o_full  = (occ_q == OCC_W'(DEPTH));
    assign o_empty = (occ_q == '0);
    assign o_occ   = occ_q;
    assign o_head  = mem_q[rd_ptr_q];

    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign do_pop  = i_pop & ~o_empty;
    assign do_push = i_push & (~o_full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = i_push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Payload storage carries no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/v_cmd_sched.sv
// Front-end scheduler for the state-table read port shared by queries and updates.
//   Query path  : i_q_* -> o_lut_* combinationally, never stalled.
//   Update path : i_u_* / o_u_rdy valid/ready into a FIFO; o_upd_* issues the head
//                 in cycles with no query and no in-flight update to the same ID.
//   Status      : o_inflight_* shadow of the update pipeline, o_upd_q_occ_r FIFO
//                 occupancy, o_starve_r sticky starvation flag (cleared by i_starve_clr).
// Handshake: an update is accepted in any cycle where i_u_vld and o_u_rdy are both
// high; o_u_rdy depends only on registered occupancy, and i_u_* must hold while
// i_u_vld is high and o_u_rdy is low.
// Optional build macro V_CMD_SCHED_BYPASS_EN: an update arriving at an empty FIFO
// with no query and no hazard issues in the same cycle without being stored.
module v_cmd_sched
    import v_pkg::*;
#(
    parameter  int UPD_Q_N      = 4,
    parameter  int UPD_STAGES_N = UPD_STAGES_N_DEF,
    parameter  int STARVE_N     = 8,
    localparam int OCC_W        = $clog2(UPD_Q_N) + 1,
    localparam int STARVE_W     = $clog2(STARVE_N + 1)
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         i_q_vld,
    input  id_t                          i_q_prod_id,
    input  level_t                       i_q_level,
    output logic                         o_lut_vld,
    output id_t                          o_lut_prod_id,
    output level_t                       o_lut_level,
    input  logic                         i_u_vld,
    input  cmd_t                         i_u_cmd,
    input  id_t                          i_u_prod_id,
    input  key_t                         i_u_key,
    input  volume_t                      i_u_volume,
    output logic                         o_u_rdy,
    output logic                         o_upd_vld,
    output cmd_t                         o_upd_cmd,
    output id_t                          o_upd_prod_id,
    output key_t                         o_upd_key,
    output volume_t                      o_upd_volume,
    output logic [UPD_STAGES_N-1:0]      o_inflight_vld_r,
    output id_t  [UPD_STAGES_N-1:0]      o_inflight_prod_id_r,
    output logic [OCC_W-1:0]             o_upd_q_occ_r,
    output logic                         o_starve_r,
    input  logic                         i_starve_clr
);

    upd_cmd_t                in_cmd;
    upd_cmd_t                head;
    upd_cmd_t                issue_cmd;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_push;
    logic                    head_hazard;
    logic                    head_issue;
    logic                    byp_issue;
    logic                    issue;

    logic [UPD_STAGES_N-1:0] inflight_vld_q, inflight_vld_d;
    id_t  [UPD_STAGES_N-1:0] inflight_id_q, inflight_id_d;
    logic [STARVE_W-1:0]     starve_cnt_q, starve_cnt_d;
    logic                    starve_q, starve_d;

    // Query pass-through.
    assign o_lut_vld     = i_q_vld;
    assign o_lut_prod_id = i_q_prod_id;
    assign o_lut_level   = i_q_level;

    assign o_u_rdy = ~fifo_full;
    assign in_cmd  = '{cmd: i_u_cmd, prod_id: i_u_prod_id, key: i_u_key, volume: i_u_volume};

    // Read-after-write hazard: head ID matches any live shadow stage.
    always_comb begin
        head_hazard = 1'b0;
        for (int k = 0; k < UPD_STAGES_N; k++) begin
            if (inflight_vld_q[k] && (inflight_id_q[k] == head.prod_id)) begin
                head_hazard = 1'b1;
            end
        end
    end

    assign head_issue = ~fifo_empty & ~i_q_vld & ~head_hazard;

`ifdef V_CMD_SCHED_BYPASS_EN
    logic in_hazard;

    always_comb begin
        in_hazard = 1'b0;
        for (int k = 0; k < UPD_STAGES_N; k++) begin
            if (inflight_vld_q[k] && (inflight_id_q[k] == i_u_prod_id)) begin
                in_hazard = 1'b1;
            end
        end
    end

    // Only reachable with an empty FIFO, so it never competes with head_issue.
    assign byp_issue = fifo_empty & i_u_vld & ~i_q_vld & ~in_hazard;
`else
    assign byp_issue = 1'b0;
`endif

    assign issue     = head_issue | byp_issue;
    assign issue_cmd = byp_issue ? in_cmd : head;
    // A bypassed update is consumed directly and never written into storage.
    assign fifo_push = i_u_vld & o_u_rdy & ~byp_issue;

    assign o_upd_vld     = issue;
    assign o_upd_cmd     = issue_cmd.cmd;
    assign o_upd_prod_id = issue_cmd.prod_id;
    assign o_upd_key     = issue_cmd.key;
    assign o_upd_volume  = issue_cmd.volume;

    v_cmd_sched_fifo #(
        .DEPTH (UPD_Q_N)
    ) u_fifo (
        .clk         (clk),
        .arst_n      (arst_n),
        .i_push      (fifo_push),
        .i_push_data (in_cmd),
        .i_pop       (head_issue),
        .o_head      (head),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_occ       (o_upd_q_occ_r)
    );

    // Shadow of the update pipeline: stage 1 captures this cycle's issue.
    always_comb begin
        inflight_vld_d    = inflight_vld_q;
        inflight_id_d     = inflight_id_q;
        inflight_vld_d[0] = issue;
        inflight_id_d[0]  = issue_cmd.prod_id;
        for (int k = 1; k < UPD_STAGES_N; k++) begin
            inflight_vld_d[k] = inflight_vld_q[k-1];
            inflight_id_d[k]  = inflight_id_q[k-1];
        end
    end

    // Starvation: count blocked cycles on a valid head, saturating at STARVE_N.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        starve_d     = starve_q;
        if (fifo_empty || head_issue) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != STARVE_W'(STARVE_N)) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end
        if (i_starve_clr) begin
            starve_d = 1'b0;
        end
        // Set after clear so a same-cycle set wins.
        if (starve_cnt_d == STARVE_W'(STARVE_N)) begin
            starve_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            inflight_vld_q <= '0;
            inflight_id_q  <= '0;
            starve_cnt_q   <= '0;
            starve_q       <= 1'b0;
        end else begin
            inflight_vld_q <= inflight_vld_d;
            inflight_id_q  <= inflight_id_d;
            starve_cnt_q   <= starve_cnt_d;
            starve_q       <= starve_d;
        end
    end

    assign o_inflight_vld_r     = inflight_vld_q;
    assign o_inflight_prod_id_r = inflight_id_q;
    assign o_starve_r           = starve_q;

endmodule

// File: tb/tb_v_cmd_sched.sv
// Self-checking bench for v_cmd_sched (default parameters).
module tb_v_cmd_sched;
    import v_pkg::*;

    localparam int UPD_Q_N      = 4;
    localparam int UPD_STAGES_N = 4;
    localparam int STARVE_N     = 8;
    localparam int OCC_W        = $clog2(UPD_Q_N) + 1;
    localparam int UPD_W        = $bits(upd_cmd_t);

    logic                    clk;
    logic                    arst_n;
    logic                    i_q_vld;
    id_t                     i_q_prod_id;
    level_t                  i_q_level;
    logic                    o_lut_vld;
    id_t                     o_lut_prod_id;
    level_t                  o_lut_level;
    logic                    i_u_vld;
    cmd_t                    i_u_cmd;
    id_t                     i_u_prod_id;
    key_t                    i_u_key;
    volume_t                 i_u_volume;
    logic                    o_u_rdy;
    logic                    o_upd_vld;
    cmd_t                    o_upd_cmd;
    id_t                     o_upd_prod_id;
    key_t                    o_upd_key;
    volume_t                 o_upd_volume;
    logic [UPD_STAGES_N-1:0] o_inflight_vld_r;
    id_t  [UPD_STAGES_N-1:0] o_inflight_prod_id_r;
    logic [OCC_W-1:0]        o_upd_q_occ_r;
    logic                    o_starve_r;
    logic                    i_starve_clr;

    v_cmd_sched #(
        .UPD_Q_N      (UPD_Q_N),
        .UPD_STAGES_N (UPD_STAGES_N),
        .STARVE_N     (STARVE_N)
    ) dut (
        .clk                  (clk),
        .arst_n               (arst_n),
        .i_q_vld              (i_q_vld),
        .i_q_prod_id          (i_q_prod_id),
        .i_q_level            (i_q_level),
        .o_lut_vld            (o_lut_vld),
        .o_lut_prod_id        (o_lut_prod_id),
        .o_lut_level          (o_lut_level),
        .i_u_vld              (i_u_vld),
        .i_u_cmd              (i_u_cmd),
        .i_u_prod_id          (i_u_prod_id),
        .i_u_key              (i_u_key),
        .i_u_volume           (i_u_volume),
        .o_u_rdy              (o_u_rdy),
        .o_upd_vld            (o_upd_vld),
        .o_upd_cmd            (o_upd_cmd),
        .o_upd_prod_id        (o_upd_prod_id),
        .o_upd_key            (o_upd_key),
        .o_upd_volume         (o_upd_volume),
        .o_inflight_vld_r     (o_inflight_vld_r),
        .o_inflight_prod_id_r (o_inflight_prod_id_r),
        .o_upd_q_occ_r        (o_upd_q_occ_r),
        .o_starve_r           (o_starve_r),
        .i_starve_clr         (i_starve_clr)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks   = 0;
    int n_failures = 0;
    logic [UPD_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        i_q_vld      = 1'b0;
        i_q_prod_id  = '0;
        i_q_level    = '0;
        i_u_vld      = 1'b0;
        i_u_cmd      = CMD_INSERT;
        i_u_prod_id  = '0;
        i_u_key      = '0;
        i_u_volume   = '0;
        i_starve_clr = 1'b0;
    endtask

    task automatic drive_upd(input logic vld, input id_t id);
        i_u_vld     = vld;
        i_u_prod_id = id;
        i_u_cmd     = cmd_t'($urandom_range(0, 3));
        i_u_key     = key_t'($urandom_range(0, 65535));
        i_u_volume  = volume_t'($urandom_range(0, 65535));
    endtask

    // Sample mid-cycle; accepted updates are pushed, issued updates popped and compared.
    task automatic sample();
        upd_cmd_t act;
        logic [UPD_W-1:0] exp;
        @(negedge clk);
        if (i_u_vld && o_u_rdy) begin
            exp_q.push_back({i_u_cmd, i_u_prod_id, i_u_key, i_u_volume});
        end
        if (o_upd_vld) begin
            act = '{cmd: o_upd_cmd, prod_id: o_upd_prod_id, key: o_upd_key, volume: o_upd_volume};
            if (exp_q.size() == 0) begin
                check("sb_unexpected_issue", {24'd0, o_upd_prod_id}, 32'hFFFF_FFFF);
            end else begin
                exp = exp_q.pop_front();
                n_checks++;
                if (act !== exp) begin
                    n_failures++;
                    $display("FAIL sb_issue actual=0x%0h expected=0x%0h", act, exp);
                end
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) begin
            sample();
            adv();
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic             q_vld;
        logic             u_vld;
        id_t              u_id;
        logic             exp_vld;
        logic [OCC_W-1:0] exp_occ;
        logic             exp_rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            i_q_vld = vecs[i].q_vld;
            drive_upd(vecs[i].u_vld, vecs[i].u_id);
            sample();
            check($sformatf("%s[%0d].upd_vld", tag, i), {31'd0, o_upd_vld}, {31'd0, vecs[i].exp_vld});
            check($sformatf("%s[%0d].occ", tag, i), {29'd0, o_upd_q_occ_r}, {29'd0, vecs[i].exp_occ});
            check($sformatf("%s[%0d].rdy", tag, i), {31'd0, o_u_rdy}, {31'd0, vecs[i].exp_rdy});
            adv();
        end
        vecs.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".occ"}, {29'd0, o_upd_q_occ_r}, 32'd0);
        check({tag, ".rdy"}, {31'd0, o_u_rdy}, 32'd1);
        check({tag, ".upd_vld"}, {31'd0, o_upd_vld}, 32'd0);
        check({tag, ".inflight_vld"}, {28'd0, o_inflight_vld_r}, 32'd0);
        check({tag, ".starve"}, {31'd0, o_starve_r}, 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        idle_inputs();
        arst_n = 1'b0;
        #12;
        check_reset_state("reset");
        @(negedge clk);
        arst_n = 1'b1;
        adv();

        // Query pass-through, random values.
        for (int i = 0; i < 6; i++) begin
            id_t    qid;
            level_t qlv;
            logic   qv;
            qv  = 1'($urandom_range(0, 1));
            qid = id_t'($urandom_range(0, 255));
            qlv = level_t'($urandom_range(0, 15));
            i_q_vld = qv; i_q_prod_id = qid; i_q_level = qlv;
            sample();
            check("lut_vld", {31'd0, o_lut_vld}, {31'd0, qv});
            check("lut_id", {24'd0, o_lut_prod_id}, {24'd0, qid});
            check("lut_level", {28'd0, o_lut_level}, {28'd0, qlv});
            adv();
        end
        idle_inputs();

        // Single update ID=3: issues one cycle after accept, then sits in stage 1.
        drive_upd(1'b1, 8'd3);
        sample();
        check("t1.no_issue_at_accept", {31'd0, o_upd_vld}, 32'd0);
        adv();
        idle_inputs();
        sample();
        check("t1.issue", {31'd0, o_upd_vld}, 32'd1);
        adv();
        sample();
        check("t1.stage1_vld", {31'd0, o_inflight_vld_r[0]}, 32'd1);
        check("t1.stage1_id", {24'd0, o_inflight_prod_id_r[0]}, 32'd3);
        adv();
        idle_cycles(5);

        // Starvation: 10 cycles of queries over one queued update.
        i_q_vld = 1'b1;
        drive_upd(1'b1, 8'd7);
        sample();
        adv();
        i_u_vld = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            sample();
            check($sformatf("t2.blocked%0d", i), {31'd0, o_upd_vld}, 32'd0);
            if (i == 8) check("t2.starve_before", {31'd0, o_starve_r}, 32'd0);
            if (i == 9) check("t2.starve_after", {31'd0, o_starve_r}, 32'd1);
            adv();
        end
        i_q_vld = 1'b0;
        sample();
        check("t2.issue_cycle11", {31'd0, o_upd_vld}, 32'd1);
        adv();
        i_starve_clr = 1'b1;
        sample();
        check("t2.starve_sticky", {31'd0, o_starve_r}, 32'd1);
        adv();
        i_starve_clr = 1'b0;
        sample();
        check("t2.starve_cleared", {31'd0, o_starve_r}, 32'd0);
        adv();
        idle_cycles(5);

        // Same-ID hazard: second ID=5 waits until 5 cycles after the first; ID=6 behind it.
        //           q     u     id     vld   occ   rdy
        vecs.push_back('{1'b0, 1'b1, 8'd5, 1'b0, 3'd0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 8'd5, 1'b1, 3'd1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 8'd6, 1'b0, 3'd1, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'd0, 1'b0, 3'd2, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'd0, 1'b0, 3'd2, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'd0, 1'b0, 3'd2, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'd0, 1'b1, 3'd2, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'd0, 1'b1, 3'd1, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'd0, 1'b0, 3'd0, 1'b1});
        run_vecs("t3");
        idle_cycles(5);

        // Fill under queries, 5th held, then drain one per cycle.
        vecs.push_back('{1'b1, 1'b1, 8'd10, 1'b0, 3'd0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 8'd11, 1'b0, 3'd1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 8'd12, 1'b0, 3'd2, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 8'd13, 1'b0, 3'd3, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 8'd14, 1'b0, 3'd4, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'd0,  1'b1, 3'd4, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'd0,  1'b1, 3'd3, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'd0,  1'b1, 3'd2, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'd0,  1'b1, 3'd1, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'd0,  1'b0, 3'd0, 1'b1});
        run_vecs("t4");
        idle_cycles(5);

        // Asynchronous reset mid-drain with occupancy 3 and shadow populated.
        i_q_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_upd(1'b1, id_t'(20 + i));
            sample();
            adv();
        end
        i_u_vld = 1'b0;
        sample();
        adv();
        i_q_vld = 1'b0;
        sample();
        adv();
        check("t5.pre_occ", {29'd0, o_upd_q_occ_r}, 32'd3);
        check("t5.pre_stage1", {31'd0, o_inflight_vld_r[0]}, 32'd1);
        #1 arst_n = 1'b0;
        #1;
        check_reset_state("t5.async_reset");
        exp_q.delete();
        @(negedge clk);
        arst_n = 1'b1;
        adv();
        for (int i = 0; i < 4; i++) begin
            sample();
            check($sformatf("t5.no_issue%0d", i), {31'd0, o_upd_vld}, 32'd0);
            check($sformatf("t5.occ%0d", i), {29'd0, o_upd_q_occ_r}, 32'd0);
            adv();
        end

        // Empty-FIFO update with no query, then one arriving under a query.
        drive_upd(1'b1, 8'd9);
        sample();
`ifdef V_CMD_SCHED_BYPASS_EN
        check("t6.bypass_same_cycle", {31'd0, o_upd_vld}, 32'd1);
        adv();
        idle_inputs();
        sample();
        check("t6.bypass_occ", {29'd0, o_upd_q_occ_r}, 32'd0);
        check("t6.bypass_no_repeat", {31'd0, o_upd_vld}, 32'd0);
        adv();
`else
        check("t6.no_bypass", {31'd0, o_upd_vld}, 32'd0);
        adv();
        idle_inputs();
        sample();
        check("t6.next_cycle_issue", {31'd0, o_upd_vld}, 32'd1);
        check("t6.occ", {29'd0, o_upd_q_occ_r}, 32'd1);
        adv();
`endif
        i_q_vld = 1'b1;
        drive_upd(1'b1, 8'd40);
        sample();
        check("t6.query_blocks", {31'd0, o_upd_vld}, 32'd0);
        adv();
        idle_inputs();
        sample();
        check("t6.queued_issue", {31'd0, o_upd_vld}, 32'd1);
        check("t6.queued_occ", {29'd0, o_upd_q_occ_r}, 32'd1);
        adv();
        idle_cycles(3);

        check("sb_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule

// File: doc/v_cmd_sched.md
Name: v_cmd_sched

Overview:
- Front-end scheduler for the single state-table read port shared by the query pipeline and the update pipeline.
- Queries are latency-critical: they pass straight through to the query pipeline and are never stalled.
- Update commands enter through a valid/ready FIFO. They issue to the update pipeline only in cycles with no query, and never while an earlier update to the same prod_id is in flight (read-after-write hazard).
- Keeps a shadow of in-flight update IDs and reports starvation and occupancy status.

Parameters:
- UPD_Q_N, 4, update FIFO depth (power of two, 2..16).
- UPD_STAGES_N, 4, update pipeline depth tracked by the in-flight shadow.
- STARVE_N, 8, consecutive blocked cycles on a valid FIFO head before o_starve is set.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- i_q_vld  in  1  query request
- i_q_prod_id  in  v_pkg::id_t  query ID
- i_q_level  in  v_pkg::level_t  query level
- o_lut_vld  out  1  query issue to the query pipeline (equals i_q_vld)
- o_lut_prod_id  out  v_pkg::id_t  query ID, passed through
- o_lut_level  out  v_pkg::level_t  query level, passed through
- i_u_vld  in  1  update request
- i_u_cmd  in  v_pkg::cmd_t  update opcode
- i_u_prod_id  in  v_pkg::id_t  update ID
- i_u_key  in  v_pkg::key_t  update key
- i_u_volume  in  v_pkg::volume_t  update volume
- o_u_rdy  out  1  update accept; equals FIFO not full
- o_upd_vld  out  1  update issue
- o_upd_cmd  out  v_pkg::cmd_t  issued opcode
- o_upd_prod_id  out  v_pkg::id_t  issued ID
- o_upd_key  out  v_pkg::key_t  issued key
- o_upd_volume  out  v_pkg::volume_t  issued volume
- o_inflight_vld_r  out  UPD_STAGES_N  shadow valid bits; bit k = stage k+1
- o_inflight_prod_id_r  out  UPD_STAGES_N x id_t  shadow IDs
- o_upd_q_occ_r  out  $clog2(UPD_Q_N)+1  FIFO occupancy
- o_starve_r  out  1  sticky starvation flag
- i_starve_clr  in  1  clears o_starve_r

Behaviour:
- Reset (arst_n low, asynchronous):
  - FIFO empty; o_upd_q_occ_r=0; o_u_rdy=1.
  - Shadow valid bits=0; starvation counter=0; o_starve_r=0; o_upd_vld=0.
- Query path is purely combinational, zero latency.
  - o_lut_* mirror i_q_* in every cycle.
  - Queries are never back-pressured.
- Enqueue: the FIFO pushes when i_u_vld & o_u_rdy.
- Issue condition: head valid & !i_q_vld & !hazard.
  - hazard = head prod_id matches any shadow stage k with vld_r[k]=1.
  - On issue, pop the head and drive o_upd_* from it in the same cycle (FIFO head is registered storage).
- Shadow register: stage 1 <= {o_upd_vld, o_upd_prod_id}; stage k+1 <= stage k; shifts every cycle.
- An update issued in cycle t blocks same-ID updates for cycles t+1..t+UPD_STAGES_N. The earliest re-issue of the same ID is cycle t+UPD_STAGES_N+1.
- Simultaneous push and pop: occupancy is unchanged. Push and pop on a full FIFO is legal only when a pop occurs; o_u_rdy is based on registered occupancy only.
- Pointers wrap modulo UPD_Q_N. Occupancy counts 0..UPD_Q_N.
- Starvation counter:
  - Increments in each cycle where the head is valid and the head does not issue.
  - Resets to 0 on issue or when the FIFO is empty.
  - Saturates at STARVE_N; on reaching STARVE_N, o_starve_r is set.
- o_starve_r stays set until i_starve_clr. If clear and set occur in the same cycle, set wins.
- Ordering: updates issue in strict FIFO order. A hazard at the head blocks younger independent updates; no reordering.

Optional Feature:
- Macro V_CMD_SCHED_BYPASS_EN.
- Defined: when the FIFO is empty, i_u_vld=1, !i_q_vld and no hazard on i_u_prod_id, the incoming update issues in the same cycle. It is not written into the FIFO, and the starvation counter is unaffected.
- Undefined: every update passes through the FIFO, so minimum accept-to-issue latency is 1 cycle.

Decomposition:
- v_pkg holds:
  - cmd_t, with opcodes CMD_INSERT, CMD_DELETE, CMD_REPLACE, CMD_CLEAR.
  - upd_cmd_t: a struct of cmd, prod_id, key, volume.
  - UPD_STAGES_N default.
- One sub-module, v_cmd_sched_fifo: a generic synchronous FIFO of upd_cmd_t with push/pop, full/empty and occupancy outputs, reset asynchronously by arst_n.
- Hazard compare and shadow shift register live in the top level.

Test Plan:
- Reset then enqueue a single update ID=3, no queries -> o_upd_vld=1 one cycle after accept (bypass off); shadow stage 1 holds ID 3 in the next cycle.
- Continuous i_q_vld for 10 cycles with one queued update -> no issue for 10 cycles; o_starve_r=1 after the 8th blocked cycle; issue in cycle 11; i_starve_clr drops the flag.
- Back-to-back updates ID=5, ID=5 -> second issues exactly 5 cycles after the first (UPD_STAGES_N=4); an interleaved ID=6 queued behind it also waits (in-order).
- Fill the FIFO with 4 updates under continuous queries -> o_u_rdy=0, o_upd_q_occ_r=4; a 5th i_u_vld is held; queries stop -> one issue per cycle with distinct IDs, occupancy 4,3,2,1,0.
- Assert arst_n low mid-drain with occupancy 3 and shadow populated -> all outputs return to reset values immediately; no issue after release until new input.
- With V_CMD_SCHED_BYPASS_EN, empty FIFO, update ID=9, no query -> o_upd_vld=1 in the same cycle and occupancy stays 0; with a query present in that cycle -> enqueued and issued next free cycle.
